// File: rtl/imuldiv_div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_div_arbiter_pkg
//  Description : Shared message layouts and requester ids for the divider
//                arbiter and its source-tag FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package imuldiv_div_arbiter_pkg;

    // Divider request message: {fn, a, b}
    localparam int IMULDIV_DIVREQ_MSG_SZ         = 65;
    localparam int IMULDIV_DIVREQ_MSG_FUNC_FIELD = 64;
    localparam int IMULDIV_DIVREQ_MSG_A_MSB      = 63;
    localparam int IMULDIV_DIVREQ_MSG_A_LSB      = 32;
    localparam int IMULDIV_DIVREQ_MSG_B_MSB      = 31;
    localparam int IMULDIV_DIVREQ_MSG_B_LSB      = 0;

    // Divider response message: {remainder, quotient}
    localparam int IMULDIV_DIVRESP_MSG_SZ        = 64;
    localparam int IMULDIV_DIVRESP_MSG_REM_MSB   = 63;
    localparam int IMULDIV_DIVRESP_MSG_REM_LSB   = 32;
    localparam int IMULDIV_DIVRESP_MSG_QUOT_MSB  = 31;
    localparam int IMULDIV_DIVRESP_MSG_QUOT_LSB  = 0;

    // Requester identifiers, also the payload of the source-tag FIFO
    typedef logic req_id_t;
    localparam req_id_t REQ_ID_0 = 1'b0;
    localparam req_id_t REQ_ID_1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imuldiv_div_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_div_tag_fifo
//  Description : In-order FIFO of 1-bit requester tags, one entry per divider
//                request in flight. Synchronous reset, no bypass: a pushed tag
//                becomes visible at the head only on the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_div_tag_fifo
    import imuldiv_div_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  req_id_t push_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             w_push_en;
    logic             w_pop_en;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign w_push_en = push_i && !full_o;
    assign w_pop_en  = pop_i && !empty_o;

    // Next pointers wrap at DEPTH (which need not fill the pointer width); count tracks occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (w_pop_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (w_push_en && !w_pop_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_pop_en && !w_push_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Register pointers, occupancy and tag storage
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imuldiv_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_div_arbiter
//  Description : Shares one in-order iterative divider between two val/rdy
//                requesters. Round-robin request arbitration, source tags kept
//                in a FIFO, responses steered back to the issuing requester.
//                Zero added latency on both request and response paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_div_arbiter
    import imuldiv_div_arbiter_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              req0_val,
    output logic                              req0_rdy,
    input  logic [IMULDIV_DIVREQ_MSG_SZ-1:0]  req0_msg,

    input  logic                              req1_val,
    output logic                              req1_rdy,
    input  logic [IMULDIV_DIVREQ_MSG_SZ-1:0]  req1_msg,

    output logic                              resp0_val,
    input  logic                              resp0_rdy,
    output logic [IMULDIV_DIVRESP_MSG_SZ-1:0] resp0_msg,

    output logic                              resp1_val,
    input  logic                              resp1_rdy,
    output logic [IMULDIV_DIVRESP_MSG_SZ-1:0] resp1_msg,

    output logic                              divreq_val,
    input  logic                              divreq_rdy,
    output logic [IMULDIV_DIVREQ_MSG_SZ-1:0]  divreq_msg,

    input  logic                              divresp_val,
    output logic                              divresp_rdy,
    input  logic [IMULDIV_DIVRESP_MSG_SZ-1:0] divresp_msg
);

    req_id_t prio_q, prio_d;
    req_id_t w_grant;
    req_id_t w_head;
    logic    w_fifo_full;
    logic    w_fifo_empty;
    logic    w_can_issue;
    logic    w_req_fire;
    logic    w_resp_fire;
    logic    w_head_rdy;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_can_issue = !reset && !w_fifo_full;

    // Grant the sole valid requester, or the priority holder on contention / idle
    always_comb begin
        w_grant = prio_q;
        if (req0_val && req1_val) begin
            w_grant = prio_q;
        end else if (req1_val) begin
            w_grant = REQ_ID_1;
        end else if (req0_val) begin
            w_grant = REQ_ID_0;
        end
    end

    assign divreq_val = w_can_issue && (req0_val || req1_val);
    assign divreq_msg = (w_grant == REQ_ID_1) ? req1_msg : req0_msg;
    assign req0_rdy   = w_can_issue && divreq_rdy && (w_grant == REQ_ID_0);
    assign req1_rdy   = w_can_issue && divreq_rdy && (w_grant == REQ_ID_1);
    assign w_req_fire = divreq_val && divreq_rdy;

    // A winning requester hands priority to the other one
    always_comb begin
        prio_d = w_req_fire ? ~w_grant : prio_q;
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= REQ_ID_0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // ------------------------------------------------------------------
    // Response side: head tag selects the destination; depends only on
    // the FIFO state, so resp rdy never reaches the request rdys.
    // ------------------------------------------------------------------
    assign w_head_rdy  = (w_head == REQ_ID_1) ? resp1_rdy : resp0_rdy;
    assign divresp_rdy = !reset && !w_fifo_empty && w_head_rdy;
    assign resp0_val   = !reset && divresp_val && !w_fifo_empty && (w_head == REQ_ID_0);
    assign resp1_val   = !reset && divresp_val && !w_fifo_empty && (w_head == REQ_ID_1);
    assign resp0_msg   = divresp_msg;
    assign resp1_msg   = divresp_msg;
    assign w_resp_fire = divresp_val && divresp_rdy;

    imuldiv_div_tag_fifo #(
        .DEPTH       (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_req_fire),
        .push_data_i (w_grant),
        .pop_i       (w_resp_fire),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .head_o      (w_head)
    );

    // The divider must never answer when nothing is outstanding
    a_no_resp_when_empty : assert property (
        @(posedge clk) disable iff (reset) !(divresp_val && w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imuldiv_div_arbiter
//  Description : Self-checking bench for imuldiv_div_arbiter with an in-order
//                one-cycle divider model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imuldiv_div_arbiter;

    localparam int MAXI = 2;

    logic        clk;
    logic        reset;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [64:0] req0_msg, req1_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [63:0] resp0_msg, resp1_msg;
    logic        divreq_val, divreq_rdy;
    logic [64:0] divreq_msg;
    logic        divresp_val, divresp_rdy;
    logic [63:0] divresp_msg;

    // Divider model state
    logic        dm_hold;
    int          dq_cnt;
    logic [63:0] dq_head;
    logic [64:0] div_q[$];

    assign divresp_val = !dm_hold && (dq_cnt > 0);
    assign divresp_msg = dq_head;

    typedef struct packed {
        logic        dest;
        logic [63:0] msg;
    } sb_t;
    sb_t  sb_q[$];
    logic prio_m;

    typedef struct packed {
        logic r0v, r1v, drdy, hold;
        logic dv, rdy0, rdy1;
    } vec_t;
    vec_t vecs[17];

    int n_tests = 0;
    int n_fail  = 0;

    imuldiv_div_arbiter #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy), .divreq_msg(divreq_msg),
        .divresp_val(divresp_val), .divresp_rdy(divresp_rdy), .divresp_msg(divresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] div_ref(input logic [64:0] m);
        logic [31:0] a, b, q, r;
        a = m[63:32];
        b = m[31:0];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (m[64]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic vec_t v(input logic r0v, r1v, drdy, hold, dv, rdy0, rdy1);
        vec_t t;
        t.r0v = r0v; t.r1v = r1v; t.drdy = drdy; t.hold = hold;
        t.dv = dv; t.rdy0 = rdy0; t.rdy1 = rdy1;
        return t;
    endfunction

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: check outputs against the reference model at negedge,
    // update scoreboard and divider model, then advance past posedge.
    task automatic tick();
        logic e_ne, e_head, e_can, e_g, e_dv, e_r0, e_r1, e_drdy, e_v0, e_v1;
        sb_t  ent;
        @(negedge clk);
        e_ne   = (sb_q.size() > 0);
        e_head = e_ne ? sb_q[0].dest : 1'b0;
        e_can  = !reset && (sb_q.size() < MAXI);
        if (req0_val && req1_val) e_g = prio_m;
        else if (req1_val)        e_g = 1'b1;
        else if (req0_val)        e_g = 1'b0;
        else                      e_g = prio_m;
        e_dv   = e_can && (req0_val || req1_val);
        e_r0   = e_can && divreq_rdy && !e_g;
        e_r1   = e_can && divreq_rdy && e_g;
        e_drdy = !reset && e_ne && (e_head ? resp1_rdy : resp0_rdy);
        e_v0   = !reset && divresp_val && e_ne && !e_head;
        e_v1   = !reset && divresp_val && e_ne && e_head;
        check("divreq_val",  divreq_val,  e_dv);
        check("req0_rdy",    req0_rdy,    e_r0);
        check("req1_rdy",    req1_rdy,    e_r1);
        check("divresp_rdy", divresp_rdy, e_drdy);
        check("resp0_val",   resp0_val,   e_v0);
        check("resp1_val",   resp1_val,   e_v1);
        if (e_dv) check("divreq_msg", divreq_msg, e_g ? req1_msg : req0_msg);
        if (e_drdy && divresp_val) begin
            ent = sb_q.pop_front();
            check(ent.dest ? "resp1_msg" : "resp0_msg",
                  ent.dest ? resp1_msg : resp0_msg, ent.msg);
        end
        if (e_dv && divreq_rdy) begin
            ent.dest = e_g;
            ent.msg  = div_ref(e_g ? req1_msg : req0_msg);
            sb_q.push_back(ent);
            prio_m = ~e_g;
        end
        if (divresp_val && divresp_rdy && div_q.size() > 0) void'(div_q.pop_front());
        if (divreq_val && divreq_rdy) div_q.push_back(divreq_msg);
        if (reset) begin
            sb_q.delete();
            div_q.delete();
            prio_m = 1'b0;
        end
        @(posedge clk);
        #1;
        dq_cnt  = div_q.size();
        dq_head = (dq_cnt > 0) ? div_ref(div_q[0]) : 64'd0;
        #1;
    endtask

    task automatic drain();
        req0_val = 1'b0; req1_val = 1'b0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        divreq_rdy = 1'b1; dm_hold = 1'b0;
        for (int k = 0; k < 20 && (sb_q.size() > 0 || div_q.size() > 0); k++) tick();
        check("drain_empty", (sb_q.size() == 0 && div_q.size() == 0), 1'b1);
    endtask

    initial begin
        // Contention, stall, full and idle-grant table (state right after reset)
        vecs[0]  = v(1,1,1,0, 1,1,0);
        vecs[1]  = v(1,1,1,0, 1,0,1);
        vecs[2]  = v(1,1,1,0, 1,1,0);
        vecs[3]  = v(1,1,1,0, 1,0,1);
        vecs[4]  = v(1,1,0,0, 1,0,0);
        vecs[5]  = v(1,1,0,0, 1,0,0);
        vecs[6]  = v(1,1,1,0, 1,1,0);
        vecs[7]  = v(1,1,1,1, 1,0,1);
        vecs[8]  = v(1,1,1,1, 0,0,0);
        vecs[9]  = v(1,1,1,1, 0,0,0);
        vecs[10] = v(1,1,1,0, 0,0,0);
        vecs[11] = v(1,1,1,0, 1,1,0);
        vecs[12] = v(0,0,1,0, 0,0,1);
        vecs[13] = v(0,1,1,0, 1,0,1);
        vecs[14] = v(1,0,1,0, 1,1,0);
        vecs[15] = v(0,0,1,0, 0,0,1);
        vecs[16] = v(0,0,1,0, 0,0,1);

        reset = 1'b1;
        req0_val = 1'b0; req1_val = 1'b0;
        req0_msg = '0;   req1_msg = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        divreq_rdy = 1'b1;
        dm_hold = 1'b0; dq_cnt = 0; dq_head = '0;
        prio_m = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_divreq_val", divreq_val, 1'b0);
        check("reset_divresp_rdy", divresp_rdy, 1'b0);

        for (int i = 0; i < 17; i++) begin
            req0_val   = vecs[i].r0v;
            req1_val   = vecs[i].r1v;
            divreq_rdy = vecs[i].drdy;
            dm_hold    = vecs[i].hold;
            req0_msg   = {i[0], 32'(1000 + 37 * i), 32'(3 + i)};
            req1_msg   = {1'b1, 32'(-91 * i - 5), 32'(5 + i)};
            #1;
            check($sformatf("vec%0d_dv", i),   divreq_val, vecs[i].dv);
            check($sformatf("vec%0d_rdy0", i), req0_rdy,   vecs[i].rdy0);
            check($sformatf("vec%0d_rdy1", i), req1_rdy,   vecs[i].rdy1);
            tick();
        end
        drain();

        // Single requester, signed divide of -7 by 2
        req0_val = 1'b1; req1_val = 1'b0;
        req0_msg = {1'b1, 32'hFFFF_FFF9, 32'd2};
        #1;
        check("single_divreq_msg", divreq_msg, {1'b1, 32'hFFFF_FFF9, 32'd2});
        tick();
        req0_val = 1'b0;
        #1;
        check("single_resp0_val", resp0_val, 1'b1);
        check("single_resp1_val", resp1_val, 1'b0);
        check("single_resp0_msg", resp0_msg, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();
        drain();

        // Response backpressure with head tag = 1
        req1_val = 1'b1; req1_msg = {1'b0, 32'd100, 32'd7};
        resp1_rdy = 1'b0; resp0_rdy = 1'b1;
        tick();
        req1_val = 1'b0;
        req0_msg = {1'b0, 32'd9, 32'd4};
        for (int k = 0; k < 5; k++) begin
            req0_val = (k == 0);
            #1;
            check("bp_divresp_rdy", divresp_rdy, 1'b0);
            check("bp_resp0_val",   resp0_val,   1'b0);
            check("bp_resp1_val",   resp1_val,   1'b1);
            check("bp_resp1_msg",   resp1_msg,   64'h0000_0002_0000_000E);
            tick();
        end
        resp1_rdy = 1'b1;
        tick();
        drain();

        // Reset while two requests are outstanding
        dm_hold = 1'b1;
        req0_val = 1'b1; req0_msg = {1'b0, 32'd77, 32'd5};
        tick();
        tick();
        #1;
        check("full_divreq_val", divreq_val, 1'b0);
        reset = 1'b1; req1_val = 1'b1; dm_hold = 1'b0;
        #1;
        check("rst_divreq_val",  divreq_val,  1'b0);
        check("rst_req0_rdy",    req0_rdy,    1'b0);
        check("rst_req1_rdy",    req1_rdy,    1'b0);
        check("rst_divresp_rdy", divresp_rdy, 1'b0);
        check("rst_resp0_val",   resp0_val,   1'b0);
        check("rst_resp1_val",   resp1_val,   1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_divreq_val", divreq_val, 1'b1);
        check("post_rst_req0_rdy",   req0_rdy,   1'b1);
        check("post_rst_req1_rdy",   req1_rdy,   1'b0);
        tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
